ym_phase_seq: RTL

YM_PHASE_SEQ -- requirements
Module: ym_phase_seq

---
 rtl/ym_phase_seq_pkg.sv | 14 +
 rtl/ym_phase_decode.sv | 43 ++++
 rtl/ym_phase_seq.sv | 125 ++++++++++++
 3 files changed

// File: rtl/ym_phase_seq_pkg.sv
// rtl/ym_phase_seq_pkg.sv - shared constants and debug FSM encoding for ym_phase_seq
// Contents: default MCLK-per-slot divider, default slots per frame, debug-read FSM states.
package ym_phase_seq_pkg;

    localparam int DEF_DIV   = 6;
    localparam int DEF_SLOTS = 24;

    typedef enum logic [1:0] {
        DBG_IDLE  = 2'd0,
        DBG_ARMED = 2'd1,
        DBG_LOAD  = 2'd2
    } dbg_state_t;

endpackage

// File: rtl/ym_phase_decode.sv
// rtl/ym_phase_decode.sv - phase index to registered c1/c2 clock enables plus dead-cycle flags
// Ports:
//   clk, reset        : master clock, synchronous active-high reset
//   en                : run enable; low forces c1/c2 low on the next cycle
//   p                 : phase being executed at this edge
//   c1, c2            : registered phase-1 / phase-2 enables for the coming cycle
//   dead_mid, dead_end: p sits on the gap after the c1 window / after the c2 window (wrap point)
module ym_phase_decode #(
    parameter int DIV = ym_phase_seq_pkg::DEF_DIV,
    parameter int PW  = $clog2(DIV)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic [PW-1:0] p,
    output logic          c1,
    output logic          c2,
    output logic          dead_mid,
    output logic          dead_end
);

    localparam logic [PW-1:0] C1_LAST  = PW'(DIV/2 - 2);
    localparam logic [PW-1:0] C2_FIRST = PW'(DIV/2);
    localparam logic [PW-1:0] C2_LAST  = PW'(DIV - 2);
    localparam logic [PW-1:0] P_MID    = PW'(DIV/2 - 1);
    localparam logic [PW-1:0] P_LAST   = PW'(DIV - 1);

    assign dead_mid = (p == P_MID);
    assign dead_end = (p == P_LAST);

    // The two windows are disjoint and each is followed by a gap phase,
    // so c1 and c2 can never overlap.
    always_ff @(posedge clk) begin
        if (reset) begin
            c1 <= 1'b0;
            c2 <= 1'b0;
        end else begin
            c1 <= en && (p <= C1_LAST);
            c2 <= en && (p >= C2_FIRST) && (p <= C2_LAST);
        end
    end

endmodule

// File: rtl/ym_phase_seq.sv
// rtl/ym_phase_seq.sv - two-phase clock-enable, slot and frame sequencer with debug-load FSM
// Ports:
//   MCLK, reset        : master clock, synchronous active-high reset
//   en                 : run enable; low freezes phase/slot and gates c1/c2/dbg_load
//   sync_in            : frame realign request, rising edge restarts at slot 0 phase 0
//   dbg_req            : request a debug-chain load in the next slot-0 c1 window
//   c1, c2             : non-overlapping phase enables
//   slot, frame_start  : slot index of the current cycle, high while slot is 0
//   dbg_load, dbg_ack  : debug chain load strobe and one-cycle completion pulse
module ym_phase_seq
    import ym_phase_seq_pkg::*;
#(
    parameter int DIV   = DEF_DIV,
    parameter int SLOTS = DEF_SLOTS
) (
    input  logic       MCLK,
    input  logic       reset,
    input  logic       en,
    input  logic       sync_in,
    input  logic       dbg_req,
    output logic       c1,
    output logic       c2,
    output logic [4:0] slot,
    output logic       frame_start,
    output logic       dbg_load,
    output logic       dbg_ack
);

    localparam int PW = $clog2(DIV);
    localparam logic [4:0] S_LAST = 5'(SLOTS - 1);

    // p_cnt/s_cnt hold the phase and slot to be executed at the next enabled
    // edge; the registered outputs always describe the phase just executed.
    logic [PW-1:0] p_cnt;
    logic [4:0]    s_cnt;
    logic [PW-1:0] e_p;
    logic [4:0]    e_s;
    logic          hist;
    logic          rise;
    logic          dead_mid;
    logic          dead_end;
    dbg_state_t    state;

    assign rise = sync_in && !hist;
    // A realign makes this very edge execute slot 0 phase 0.
    assign e_p  = rise ? '0 : p_cnt;
    assign e_s  = rise ? '0 : s_cnt;

    ym_phase_decode #(
        .DIV (DIV),
        .PW  (PW)
    ) u_decode (
        .clk      (MCLK),
        .reset    (reset),
        .en       (en),
        .p        (e_p),
        .c1       (c1),
        .c2       (c2),
        .dead_mid (dead_mid),
        .dead_end (dead_end)
    );

    always_ff @(posedge MCLK) begin
        if (reset) begin
            p_cnt       <= '0;
            s_cnt       <= '0;
            slot        <= '0;
            frame_start <= 1'b1;
            hist        <= 1'b0;
            state       <= DBG_IDLE;
            dbg_load    <= 1'b0;
            dbg_ack     <= 1'b0;
        end else begin
            hist     <= sync_in;
            dbg_load <= 1'b0;
            dbg_ack  <= 1'b0;

            if (en) begin
                slot        <= e_s;
                frame_start <= (e_s == '0);
                if (dead_end) begin
                    p_cnt <= '0;
                    s_cnt <= (e_s == S_LAST) ? '0 : e_s + 5'd1;
                end else begin
                    p_cnt <= e_p + PW'(1);
                    s_cnt <= e_s;
                end
            end else if (rise) begin
                // Realign while frozen: resume later from slot 0 phase 0.
                p_cnt       <= '0;
                s_cnt       <= '0;
                slot        <= '0;
                frame_start <= 1'b1;
            end

            case (state)
                DBG_IDLE: begin
                    // The cycle showing dbg_ack does not accept a new request.
                    if (dbg_req && !dbg_ack) state <= DBG_ARMED;
                end
                DBG_ARMED: begin
                    if (en && (e_p == '0) && (e_s == '0)) begin
                        state    <= DBG_LOAD;
                        dbg_load <= 1'b1;
                    end
                end
                DBG_LOAD: begin
                    if (rise) begin
                        state <= DBG_ARMED;
                    end else if (en) begin
                        // The gap after the c1 window ends the load.
                        if (dead_mid) begin
                            state   <= DBG_IDLE;
                            dbg_ack <= 1'b1;
                        end else begin
                            dbg_load <= 1'b1;
                        end
                    end
                end
                default: state <= DBG_IDLE;
            endcase
        end
    end

endmodule
